hazard_scoreboard_unit: RTL and testbench

Parametrised successor of the pipeline hazard unit. It keeps a per-register scoreboard of in-flight writers (loads with configurable latency, multi-cycle MDU ops), detects RAW, WAW and MDU structural hazards, and squashes scoreboard state for instructions flushed by a MEM-stage branch/jump. It also drives ID-stage forwarding selects, including a new MDU-completion source, and keeps saturating stall/flush performance counters. It sits beside the IF/ID/EX/MEM/WB pipeline registers and replaces the combinational hazard unit.

---
 rtl/hazard_scoreboard_unit_pkg.sv | 26 ++
 rtl/hz_scoreboard.sv | 66 ++++++
 rtl/hazard_scoreboard_unit.sv | 129 ++++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared encodings for the hazard scoreboard: instruction classes, forward
// selects and the default PC select.
package hazard_scoreboard_unit_pkg;

   typedef enum logic [1:0] {
      HZ_CLASS_ALU  = 2'b00,
      HZ_CLASS_LOAD = 2'b01,
      HZ_CLASS_MDU  = 2'b10,
      HZ_CLASS_RSVD = 2'b11
   } hz_class_e;

   typedef enum logic [1:0] {
      FWD_SEL_RF  = 2'b00,
      FWD_SEL_MEM = 2'b01,
      FWD_SEL_WB  = 2'b10,
      FWD_SEL_MDU = 2'b11
   } fwd_sel_e;

   localparam logic [1:0] PC_SEL_PC_PLUS_4 = 2'b00;

   // The reserved class encoding behaves exactly like an ALU op.
   function automatic hz_class_e norm_class(input logic [1:0] c);
      return (c == HZ_CLASS_RSVD) ? HZ_CLASS_ALU : hz_class_e'(c);
   endfunction

endpackage

// File: rtl/hz_scoreboard.sv
// Per-register record of in-flight writers: load latency down-counters and
// MDU-pending bits, with pending lookups for rs1, rs2 and rd.
module hz_scoreboard #(
   parameter int NUM_REGS     = 32,
   parameter int REG_AW       = 5,
   parameter int LOAD_LATENCY = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              set_load_i,
   input  logic              set_mdu_i,
   input  logic [REG_AW-1:0] set_rd_i,
   input  logic              done_i,
   input  logic [REG_AW-1:0] done_rd_i,
   input  logic              clr_i,
   input  logic [REG_AW-1:0] clr_rd_i,
   input  logic [REG_AW-1:0] rs1_i,
   input  logic [REG_AW-1:0] rs2_i,
   input  logic [REG_AW-1:0] rd_i,
   output logic              pend_rs1_o,
   output logic              pend_rs2_o,
   output logic              pend_rd_o
);

   localparam int LAT_W = (LOAD_LATENCY < 2) ? 1 : $clog2(LOAD_LATENCY + 1);
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LOAD_LATENCY);

   logic [LAT_W-1:0]    cnt [NUM_REGS];
   logic [NUM_REGS-1:0] mdu_pend;

   // Entry 0 is never written after reset, so it stays clear.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
         mdu_pend <= '0;
      end else begin
         for (int r = 1; r < NUM_REGS; r++) begin
            if (clr_i && clr_rd_i == REG_AW'(r)) begin
               cnt[r]      <= '0;
               mdu_pend[r] <= 1'b0;
            end else begin
               if (set_load_i && set_rd_i == REG_AW'(r))
                  cnt[r] <= LAT_INIT;
               else if (cnt[r] != '0)
                  cnt[r] <= cnt[r] - 1'b1;

               if (set_mdu_i && set_rd_i == REG_AW'(r))
                  mdu_pend[r] <= 1'b1;
               else if (done_i && done_rd_i == REG_AW'(r))
                  mdu_pend[r] <= 1'b0;
            end
         end
      end
   end

   // An MDU result arriving this cycle no longer counts as pending.
   function automatic logic pend(input logic [REG_AW-1:0] a);
      if (a == '0 || int'(a) >= NUM_REGS) return 1'b0;
      return (cnt[a] != '0) || (mdu_pend[a] && !(done_i && done_rd_i == a));
   endfunction

   assign pend_rs1_o = pend(rs1_i);
   assign pend_rs2_o = pend(rs2_i);
   assign pend_rd_o  = pend(rd_i);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Scoreboard-based hazard unit: RAW/WAW/MDU-structural stalls, MEM-stage
// flush with EX squash, ID forwarding selects and saturating perf counters.
module hazard_scoreboard_unit
   import hazard_scoreboard_unit_pkg::*;
#(
   parameter int NUM_REGS     = 32,
   parameter int REG_AW       = 5,
   parameter int LOAD_LATENCY = 1,
   parameter int CNT_W        = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              id_valid_i,
   input  logic [REG_AW-1:0] id_rs1_addr_i,
   input  logic [REG_AW-1:0] id_rs2_addr_i,
   input  logic              id_rs1_used_i,
   input  logic              id_rs2_used_i,
   input  logic [REG_AW-1:0] id_rd_addr_i,
   input  logic              id_reg_write_i,
   input  logic [1:0]        id_class_i,
   input  logic [REG_AW-1:0] mem_rd_addr_i,
   input  logic              mem_reg_write_i,
   input  logic [REG_AW-1:0] wb_rd_addr_i,
   input  logic              wb_reg_write_i,
   input  logic              mdu_done_i,
   input  logic [REG_AW-1:0] mdu_rd_addr_i,
   input  logic              branch_jump_request_mem_i,
   input  logic [1:0]        pc_sel_decision_mem_i,
   output logic              pc_stall_o,
   output logic              if_id_stall_o,
   output logic              if_id_flush_o,
   output logic              id_ex_flush_o,
   output logic              mdu_kill_o,
   output logic [1:0]        forward_a_select_o,
   output logic [1:0]        forward_b_select_o,
   output logic [1:0]        pc_sel_final_o,
   output logic [CNT_W-1:0]  stall_count_o,
   output logic [CNT_W-1:0]  flush_count_o
);

   hz_class_e         id_cls;
   logic              pend_rs1, pend_rs2, pend_rd;
   logic              raw, waw, structural, flush, stall, issue;
   logic              id_writes, set_load, set_mdu, squash;
   logic              mdu_busy;
   logic              ex_valid, ex_wr;
   logic [REG_AW-1:0] ex_rd;
   hz_class_e         ex_cls;
   logic [CNT_W-1:0]  stall_cnt, flush_cnt;

   assign id_cls     = norm_class(id_class_i);
   assign raw        = (id_rs1_used_i && pend_rs1) || (id_rs2_used_i && pend_rs2);
   assign waw        = id_reg_write_i && pend_rd;
   assign structural = (id_cls == HZ_CLASS_MDU) && mdu_busy && !mdu_done_i;
   assign flush      = branch_jump_request_mem_i;
   assign stall      = id_valid_i && (raw || waw || structural) && !flush;
   assign issue      = id_valid_i && !stall && !flush;
   assign id_writes  = issue && id_reg_write_i && (id_rd_addr_i != '0);
   assign set_load   = id_writes && (id_cls == HZ_CLASS_LOAD);
   assign set_mdu    = id_writes && (id_cls == HZ_CLASS_MDU);
   assign squash     = flush && ex_valid;

   hz_scoreboard #(
      .NUM_REGS     (NUM_REGS),
      .REG_AW       (REG_AW),
      .LOAD_LATENCY (LOAD_LATENCY)
   ) u_sb (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .set_load_i (set_load),
      .set_mdu_i  (set_mdu),
      .set_rd_i   (id_rd_addr_i),
      .done_i     (mdu_done_i),
      .done_rd_i  (mdu_rd_addr_i),
      .clr_i      (squash && ex_wr),
      .clr_rd_i   (ex_rd),
      .rs1_i      (id_rs1_addr_i),
      .rs2_i      (id_rs2_addr_i),
      .rd_i       (id_rd_addr_i),
      .pend_rs1_o (pend_rs1),
      .pend_rs2_o (pend_rs2),
      .pend_rd_o  (pend_rd)
   );

   // Squash of an in-flight MDU op overrides a same-cycle done or new issue.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mdu_busy  <= 1'b0;
         ex_valid  <= 1'b0;
         ex_wr     <= 1'b0;
         ex_rd     <= '0;
         ex_cls    <= HZ_CLASS_ALU;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (squash && ex_cls == HZ_CLASS_MDU) mdu_busy <= 1'b0;
         else if (set_mdu)                     mdu_busy <= 1'b1;
         else if (mdu_done_i)                  mdu_busy <= 1'b0;

         ex_valid <= issue;
         ex_wr    <= issue && id_reg_write_i;
         ex_rd    <= issue ? id_rd_addr_i : '0;
         ex_cls   <= issue ? id_cls : HZ_CLASS_ALU;

         if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
         if (flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      end
   end

   function automatic fwd_sel_e fwd(input logic [REG_AW-1:0] rs);
      if (rs == '0)                                  return FWD_SEL_RF;
      if (mem_reg_write_i && mem_rd_addr_i == rs)    return FWD_SEL_MEM;
      if (mdu_done_i && mdu_rd_addr_i == rs)         return FWD_SEL_MDU;
      if (wb_reg_write_i && wb_rd_addr_i == rs)      return FWD_SEL_WB;
      return FWD_SEL_RF;
   endfunction

   assign pc_stall_o         = stall;
   assign if_id_stall_o      = stall;
   assign if_id_flush_o      = flush;
   assign id_ex_flush_o      = stall || flush;
   assign mdu_kill_o         = squash && (ex_cls == HZ_CLASS_MDU);
   assign forward_a_select_o = fwd(id_rs1_addr_i);
   assign forward_b_select_o = fwd(id_rs2_addr_i);
   assign pc_sel_final_o     = flush ? pc_sel_decision_mem_i : PC_SEL_PC_PLUS_4;
   assign stall_count_o      = stall_cnt;
   assign flush_count_o      = flush_cnt;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: the driver queues hand-computed
// expectations each cycle; a negedge monitor pops and compares them.
module tb_hazard_scoreboard_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, rs1_used, rs2_used, reg_write;
   logic [4:0] rs1, rs2, rd;
   logic [1:0] cls;
   logic [4:0] mem_rd, wb_rd, mdu_rd;
   logic       mem_wr, wb_wr, mdu_done, bj;
   logic [1:0] pc_dec;

   logic        pc_stall, if_id_stall, if_id_flush, id_ex_flush, mdu_kill;
   logic [1:0]  fa, fb, pc_sel;
   logic [15:0] stall_count, flush_count;

   always #5 clk = ~clk;

   hazard_scoreboard_unit #(
      .NUM_REGS (32), .REG_AW (5), .LOAD_LATENCY (2), .CNT_W (16)
   ) dut (
      .clk_i                     (clk),
      .rst_i                     (rst),
      .id_valid_i                (id_valid),
      .id_rs1_addr_i             (rs1),
      .id_rs2_addr_i             (rs2),
      .id_rs1_used_i             (rs1_used),
      .id_rs2_used_i             (rs2_used),
      .id_rd_addr_i              (rd),
      .id_reg_write_i            (reg_write),
      .id_class_i                (cls),
      .mem_rd_addr_i             (mem_rd),
      .mem_reg_write_i           (mem_wr),
      .wb_rd_addr_i              (wb_rd),
      .wb_reg_write_i            (wb_wr),
      .mdu_done_i                (mdu_done),
      .mdu_rd_addr_i             (mdu_rd),
      .branch_jump_request_mem_i (bj),
      .pc_sel_decision_mem_i     (pc_dec),
      .pc_stall_o                (pc_stall),
      .if_id_stall_o             (if_id_stall),
      .if_id_flush_o             (if_id_flush),
      .id_ex_flush_o             (id_ex_flush),
      .mdu_kill_o                (mdu_kill),
      .forward_a_select_o        (fa),
      .forward_b_select_o        (fb),
      .pc_sel_final_o            (pc_sel),
      .stall_count_o             (stall_count),
      .flush_count_o             (flush_count)
   );

   typedef struct {
      string       name;
      logic [11:0] flags;
      logic [15:0] scnt;
      logic [15:0] fcnt;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t        e;
         logic [11:0] act;
         e   = exp_q.pop_front();
         act = {pc_stall, if_id_stall, if_id_flush, id_ex_flush, mdu_kill, fa, fb, pc_sel, 1'b0};
         vectors++;
         if (act !== e.flags || stall_count !== e.scnt || flush_count !== e.fcnt) begin
            miscompares++;
            $display("FAIL %s: got flags=%b scnt=%0d fcnt=%0d, want flags=%b scnt=%0d fcnt=%0d",
                     e.name, act, stall_count, flush_count, e.flags, e.scnt, e.fcnt);
         end
      end
   end

   // flags layout: pc_stall, if_id_stall, if_id_flush, id_ex_flush, kill, fa, fb, pc_sel, pad
   task automatic expect_out(input string n, input logic st, input logic fl, input logic kl,
                             input logic [1:0] a, input logic [1:0] b, input logic [1:0] pc,
                             input int sc, input int fc);
      exp_t e;
      e.name  = n;
      e.flags = {st, st, fl, st | fl, kl, a, b, pc, 1'b0};
      e.scnt  = 16'(sc);
      e.fcnt  = 16'(fc);
      exp_q.push_back(e);
   endtask

   task automatic idle();
      id_valid = 0; rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0;
      rd = 0; reg_write = 0; cls = 2'b00;
      mem_rd = 0; mem_wr = 0; wb_rd = 0; wb_wr = 0;
      mdu_done = 0; mdu_rd = 0; bj = 0; pc_dec = 2'b00;
   endtask

   task automatic instr(input logic [4:0] a1, input logic u1, input logic [4:0] a2,
                        input logic u2, input logic [4:0] d, input logic w, input logic [1:0] c);
      id_valid = 1; rs1 = a1; rs1_used = u1; rs2 = a2; rs2_used = u2;
      rd = d; reg_write = w; cls = c;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      idle();
   endtask

   initial begin
      idle();
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      expect_out("reset_idle", 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
      next_cycle();

      // load x5 then dependent add: two stall cycles
      instr(0, 0, 0, 0, 5, 1, 2'b01);
      expect_out("load_x5_issue", 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
      next_cycle();
      instr(5, 1, 0, 0, 6, 1, 2'b00);
      expect_out("load_use_stall1", 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
      next_cycle();
      instr(5, 1, 0, 0, 6, 1, 2'b00);
      expect_out("load_use_stall2", 1, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0);
      next_cycle();
      instr(5, 1, 0, 0, 6, 1, 2'b00);
      wb_wr = 1; wb_rd = 5;
      expect_out("load_use_go_wb", 0, 0, 0, 2'b10, 2'b00, 2'b00, 2, 0);
      next_cycle();

      // x0 never tracked
      instr(0, 0, 0, 0, 0, 1, 2'b01);
      expect_out("load_x0", 0, 0, 0, 2'b00, 2'b00, 2'b00, 2, 0);
      next_cycle();
      instr(0, 1, 0, 1, 3, 1, 2'b00);
      expect_out("use_x0", 0, 0, 0, 2'b00, 2'b00, 2'b00, 2, 0);
      next_cycle();

      // WAW against load-pending x9, then MEM beats WB on rs2
      instr(0, 0, 0, 0, 9, 1, 2'b01);
      expect_out("load_x9", 0, 0, 0, 2'b00, 2'b00, 2'b00, 2, 0);
      next_cycle();
      instr(0, 0, 0, 0, 9, 1, 2'b11);
      expect_out("waw_stall1", 1, 0, 0, 2'b00, 2'b00, 2'b00, 2, 0);
      next_cycle();
      instr(0, 0, 0, 0, 9, 1, 2'b11);
      expect_out("waw_stall2", 1, 0, 0, 2'b00, 2'b00, 2'b00, 3, 0);
      next_cycle();
      instr(4, 1, 3, 1, 9, 1, 2'b11);
      mem_wr = 1; mem_rd = 3; wb_wr = 1; wb_rd = 3;
      expect_out("waw_go_mem_fwd", 0, 0, 0, 2'b00, 2'b01, 2'b00, 4, 0);
      next_cycle();

      // MDU writes x7, consumer waits for done and takes the MDU path
      instr(0, 0, 0, 0, 7, 1, 2'b10);
      expect_out("mdu_x7_issue", 0, 0, 0, 2'b00, 2'b00, 2'b00, 4, 0);
      next_cycle();
      for (int i = 0; i < 3; i++) begin
         instr(7, 1, 0, 0, 8, 1, 2'b00);
         expect_out($sformatf("mdu_raw_stall%0d", i), 1, 0, 0, 2'b00, 2'b00, 2'b00, 4 + i, 0);
         next_cycle();
      end
      instr(7, 1, 0, 0, 8, 1, 2'b00);
      mdu_done = 1; mdu_rd = 7;
      expect_out("mdu_done_fwd", 0, 0, 0, 2'b11, 2'b00, 2'b00, 7, 0);
      next_cycle();

      // structural: second MDU waits, issues on the done cycle
      instr(0, 0, 0, 0, 8, 1, 2'b10);
      expect_out("mdu_x8_issue", 0, 0, 0, 2'b00, 2'b00, 2'b00, 7, 0);
      next_cycle();
      instr(0, 0, 0, 0, 10, 1, 2'b10);
      expect_out("struct_stall1", 1, 0, 0, 2'b00, 2'b00, 2'b00, 7, 0);
      next_cycle();
      instr(0, 0, 0, 0, 10, 1, 2'b10);
      expect_out("struct_stall2", 1, 0, 0, 2'b00, 2'b00, 2'b00, 8, 0);
      next_cycle();
      instr(0, 0, 0, 0, 10, 1, 2'b10);
      mdu_done = 1; mdu_rd = 8;
      expect_out("struct_b2b_issue", 0, 0, 0, 2'b00, 2'b00, 2'b00, 9, 0);
      next_cycle();

      // flush with MDU x10 in EX
      instr(10, 1, 0, 0, 11, 1, 2'b00);
      bj = 1; pc_dec = 2'b10;
      expect_out("flush_kill", 0, 1, 1, 2'b00, 2'b00, 2'b10, 9, 0);
      next_cycle();
      instr(10, 1, 0, 0, 11, 1, 2'b10);
      expect_out("after_flush_go", 0, 0, 0, 2'b00, 2'b00, 2'b00, 9, 1);
      next_cycle();

      // reset in the middle of an MDU op with a stall active
      instr(11, 1, 0, 0, 12, 1, 2'b00);
      expect_out("pre_rst_stall", 1, 0, 0, 2'b00, 2'b00, 2'b00, 9, 1);
      next_cycle();
      instr(11, 1, 0, 0, 12, 1, 2'b00);
      rst = 1;
      expect_out("rst_cycle", 1, 0, 0, 2'b00, 2'b00, 2'b00, 10, 1);
      next_cycle();
      rst = 0;
      instr(11, 1, 0, 0, 12, 1, 2'b10);
      expect_out("post_rst_go", 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
      next_cycle();

      // MDU completion outranks WB on the same register
      instr(13, 1, 0, 0, 14, 1, 2'b00);
      mdu_done = 1; mdu_rd = 13; wb_wr = 1; wb_rd = 13;
      expect_out("mdu_over_wb", 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0);
      next_cycle();

      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
